signal_gen: RTL and testbench
=============================

// Module: signal_gen
// PURPOSE
//  Transmit-side encoder for the single-wire PWM/OWT sample protocol. Takes parallel words over
//  a valid/ready handshake, serialises them MSB first, emits a paced (o_vld, o_vld_data) sample
//  stream as level runs. The stream is sized so the line-side run-length detector decodes it.
// PARAMETERS
//  DATA_W   8   word width, bits per frame (excl. optional parity)
//  CNT_W    10  width of sample/run counters
//  MODE     1   0: PWM (high run then low run per bit); 1: OWT (one run of bit level per bit)
//  SMP_DIV  4   clocks per output sample, >=1
//  RUN_LEN  6   OWT: samples per bit, >=1
//  SYM_LEN  12  PWM: samples per bit symbol
//  ONE_HI   8   PWM: high samples for bit 1, 1..SYM_LEN-1
//  ZERO_HI  4   PWM: high samples for bit 0, 1..SYM_LEN-1
// PORTS
//  i_clk        in   1       clock
//  i_rst        in   1       asynchronous, active-high reset
//  i_tx_vld     in   1       word valid
//  i_tx_data    in   DATA_W  word to send, MSB first
//  o_tx_rdy     out  1       word accepted when i_tx_vld & o_tx_rdy
//  o_vld        out  1       one-cycle strobe per output sample
//  o_vld_data   out  1       sample level, qualified by o_vld
//  o_busy       out  1       frame in progress
// BEHAVIOUR
//  - One clock, i_clk. Reset asynchronous, active-high on i_rst. Reset values:
//    o_tx_rdy=0 while i_rst high, 1 from first clock after release; o_vld=0, o_vld_data=0, o_busy=0.
//  - FSM (all registered): IDLE -> HI -> LO -> (HI | PAR | IDLE) in PWM. IDLE -> RUN -> (RUN | PAR | IDLE) in OWT.
//    PAR exists only with the macro. In PWM it is encoded like a data bit.
//  - IDLE: o_tx_rdy=1. On accept: load shift reg, clear bit cnt, run cnt, tick cnt. Go busy.
//  - Tick cnt counts 0..SMP_DIV-1 while busy. A sample is emitted when tick==0.
//    First o_vld is 1 clock after the accept edge. Later samples follow every SMP_DIV clocks.
//  - o_vld/o_vld_data are registered and never asserted in IDLE. o_vld_data only changes with o_vld=1.
//  - OWT: each bit gives exactly RUN_LEN samples at bit level. No gap between bits.
//  - PWM bit b: hi=b?ONE_HI:ZERO_HI samples at 1, then SYM_LEN-hi samples at 0.
//  - Bit advance: after last sample of a bit, shift left, bit cnt+1.
//    After bit DATA_W-1 (or parity), return to IDLE on the clock after that sample's tick window ends.
//    o_tx_rdy rises there. At least 1 idle clock between frames; no back-to-back accept.
//  - i_tx_vld while busy is ignored. The master holds data until o_tx_rdy. i_tx_data is sampled only at accept.
//  - Counters: CNT_W bits, no wrap in legal configs. RUN_LEN, SYM_LEN, SMP_DIV < 2**CNT_W.
//  - Reset mid-frame: instant abort. Outputs go to reset values. The partial frame is dropped, not resumed.
//  - Elaboration checks: illegal ONE_HI/ZERO_HI/SMP_DIV raise $fatal under ASSERT_ON.
// CONFIGURATION
//  SIGNAL_GEN_PARITY_EN defined: after the LSB, one even-parity bit (^data) is sent in the same
//    encoding as data. Frame = DATA_W+1 bits.
//  Not defined: frame = DATA_W bits. No PAR state and no parity logic is built.
// STRUCTURE
//  signal_pkg: state enum sig_state_e {IDLE,HI,LO,RUN,PAR}; MODE_PWM=0 / MODE_OWT=1 constants;
//    function for bit sample count. Shared with the receive side.
//  Sub-module signal_tick: SMP_DIV divider with sync clear, outputs tick strobe. Top holds FSM,
//    shift reg, run/bit counters.
// TESTING
//  1 OWT, SMP_DIV=1, send 8'hA5 -> 48 consecutive o_vld. Data = 6x1,6x0,6x1,6x0,6x0,6x1,6x0,6x1.
//    o_tx_rdy low 49 clocks.
//  2 PWM, SMP_DIV=1, send 8'h80 -> first 12 samples 8x1,4x0. Then seven symbols 4x1,8x0.
//    96 samples total.
//  3 SMP_DIV=4, OWT, 8'hFF -> o_vld period 4 clocks. First o_vld 1 clock after accept. 48 strobes.
//  4 i_tx_vld held high with 8'h01 then 8'h02 -> second accept 1 idle clock after first frame ends.
//    Busy-time data changes are ignored.
//  5 Assert i_rst at sample 20 of a frame -> o_vld=0, o_busy=0 immediately. After release,
//    new word 8'h3C sent fully from bit 7.
//  6 SIGNAL_GEN_PARITY_EN, OWT, 8'h07 -> 9 bits. Last 6 samples =1 (parity of 3 ones).
//    8'h03 -> last 6 samples =0.

Source files
------------

// File: rtl/signal_pkg.sv
// ============================================================================
// Module  : signal_pkg
// Brief   : Shared types, mode constants and bit-length helper for the
//           single-wire PWM/OWT sample protocol (transmit and receive side).
// Revision: 1.0
// ============================================================================
`default_nettype none

package signal_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        RUN  = 3'd3,
        PAR  = 3'd4
    } sig_state_e;

    localparam int MODE_PWM = 0;
    localparam int MODE_OWT = 1;

    // Samples in the first level run of a bit: the whole bit for OWT,
    // the high phase for PWM.
    function automatic int bit_samples(input int mode, input logic b,
                                       input int run_len, input int one_hi,
                                       input int zero_hi);
        if (mode == MODE_OWT) begin
            return run_len;
        end
        return b ? one_hi : zero_hi;
    endfunction

endpackage

`default_nettype wire

// File: rtl/signal_tick.sv
// ============================================================================
// Module  : signal_tick
// Brief   : Sample-rate divider; strobes o_tick once every SMP_DIV enabled
//           clocks, starting on the first enabled clock after a clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module signal_tick #(
    parameter int SMP_DIV = 4,
    parameter int CNT_W   = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(SMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = (cnt_q == c_last) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_en && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/signal_gen.sv
// ============================================================================
// Module  : signal_gen
// Brief   : Transmit encoder: serialises handshaked words MSB first into a
//           paced PWM or OWT sample stream. Optional even-parity bit when
//           SIGNAL_GEN_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module signal_gen
    import signal_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 10,
    parameter int MODE    = 1,
    parameter int SMP_DIV = 4,
    parameter int RUN_LEN = 6,
    parameter int SYM_LEN = 12,
    parameter int ONE_HI  = 8,
    parameter int ZERO_HI = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tx_vld,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_tx_rdy,
    output logic              o_vld,
    output logic              o_vld_data,
    output logic              o_busy
);

`ifdef SIGNAL_GEN_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int SH_W = DATA_W + PAR_BITS;

    localparam logic [CNT_W-1:0] c_frame_bits = CNT_W'(SH_W);
    localparam logic [CNT_W-1:0] c_last_bit   = CNT_W'(SH_W - 1);
    localparam logic [CNT_W-1:0] c_run_last   = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] c_sym_len    = CNT_W'(SYM_LEN);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam sig_state_e       c_bit_state  = (MODE == MODE_PWM) ? HI : RUN;

`ifdef ASSERT_ON
    if (SMP_DIV < 1 || ONE_HI < 1 || ONE_HI > SYM_LEN - 1 ||
        ZERO_HI < 1 || ZERO_HI > SYM_LEN - 1) begin : g_param_check
        $fatal(1, "signal_gen: illegal SMP_DIV/ONE_HI/ZERO_HI");
    end
`endif

    sig_state_e       state_q, state_d;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             vld_q, vld_d;
    logic             vdat_q, vdat_d;
    logic             rdy_q, rdy_d;

    logic             tick;
    logic             tick_clr;
    logic             adv;
    logic             lvl;
    logic             cur_bit;
    logic [CNT_W-1:0] hi_len;
    logic [CNT_W-1:0] hi_last;
    logic [CNT_W-1:0] lo_last;
    logic [SH_W-1:0]  load_w;

    assign cur_bit = shift_q[SH_W-1];
    assign hi_len  = CNT_W'(bit_samples(MODE_PWM, cur_bit, RUN_LEN, ONE_HI, ZERO_HI));
    assign hi_last = hi_len - c_one;
    assign lo_last = c_sym_len - hi_len - c_one;

`ifdef SIGNAL_GEN_PARITY_EN
    assign load_w = {i_tx_data, ^i_tx_data};
`else
    assign load_w = i_tx_data;
`endif

    signal_tick #(
        .SMP_DIV(SMP_DIV),
        .CNT_W  (CNT_W)
    ) u_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (tick_clr),
        .i_en  (state_q != IDLE),
        .o_tick(tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        run_d    = run_q;
        vld_d    = 1'b0;
        vdat_d   = vdat_q;
        tick_clr = 1'b0;
        adv      = 1'b0;
        lvl      = 1'b0;

        if (state_q == IDLE) begin
            tick_clr = 1'b1;
            if (i_tx_vld && rdy_q) begin
                shift_d = load_w;
                bit_d   = '0;
                run_d   = '0;
                state_d = c_bit_state;
            end
        end else if (tick) begin
            // All bits sent: this tick closes the last sample's window.
            if (bit_q == c_frame_bits) begin
                state_d = IDLE;
            end else begin
                vld_d = 1'b1;
                run_d = run_q + c_one;
                case (state_q)
                    HI: begin
                        lvl = 1'b1;
                        if (run_q == hi_last) begin
                            run_d   = '0;
                            state_d = LO;
                        end
                    end
                    LO: begin
                        lvl = 1'b0;
                        adv = (run_q == lo_last);
                    end
`ifdef SIGNAL_GEN_PARITY_EN
                    PAR: begin
                        if (MODE == MODE_PWM) begin
                            lvl = 1'b1;
                            if (run_q == hi_last) begin
                                run_d   = '0;
                                state_d = LO;
                            end
                        end else begin
                            lvl = cur_bit;
                            adv = (run_q == c_run_last);
                        end
                    end
`endif
                    default: begin
                        lvl = cur_bit;
                        adv = (run_q == c_run_last);
                    end
                endcase
                vdat_d = lvl;
            end
        end

        if (adv) begin
            run_d   = '0;
            shift_d = shift_q << 1;
            bit_d   = bit_q + c_one;
            if (bit_q != c_last_bit) begin
                state_d = c_bit_state;
`ifdef SIGNAL_GEN_PARITY_EN
                if (bit_q == CNT_W'(DATA_W - 1)) begin
                    state_d = PAR;
                end
`endif
            end
        end

        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            run_q   <= '0;
            vld_q   <= 1'b0;
            vdat_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            run_q   <= run_d;
            vld_q   <= vld_d;
            vdat_q  <= vdat_d;
            rdy_q   <= rdy_d;
        end
    end

    assign o_tx_rdy   = rdy_q;
    assign o_vld      = vld_q;
    assign o_vld_data = vdat_q;
    assign o_busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_signal_gen.sv
// ============================================================================
// Module  : tb_signal_gen
// Brief   : Scoreboard bench for signal_gen: OWT and PWM at SMP_DIV=1, OWT at
//           SMP_DIV=4, back-to-back words, mid-frame reset, optional parity.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_signal_gen;

    localparam int RUN_LEN = 6;
    localparam int SYM_LEN = 12;
    localparam int ONE_HI  = 8;
    localparam int ZERO_HI = 4;
`ifdef SIGNAL_GEN_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] tx_vld = 3'b000;
    logic [7:0] tx_data [3];
    logic [2:0] rdy, vld, vdat, busy;

    logic sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // 0: OWT div 1, 1: PWM div 1, 2: OWT div 4
    signal_gen #(.DATA_W(8), .CNT_W(10), .MODE(1), .SMP_DIV(1), .RUN_LEN(RUN_LEN),
                 .SYM_LEN(SYM_LEN), .ONE_HI(ONE_HI), .ZERO_HI(ZERO_HI)) dut_owt (
        .i_clk(clk), .i_rst(rst), .i_tx_vld(tx_vld[0]), .i_tx_data(tx_data[0]),
        .o_tx_rdy(rdy[0]), .o_vld(vld[0]), .o_vld_data(vdat[0]), .o_busy(busy[0]));

    signal_gen #(.DATA_W(8), .CNT_W(10), .MODE(0), .SMP_DIV(1), .RUN_LEN(RUN_LEN),
                 .SYM_LEN(SYM_LEN), .ONE_HI(ONE_HI), .ZERO_HI(ZERO_HI)) dut_pwm (
        .i_clk(clk), .i_rst(rst), .i_tx_vld(tx_vld[1]), .i_tx_data(tx_data[1]),
        .o_tx_rdy(rdy[1]), .o_vld(vld[1]), .o_vld_data(vdat[1]), .o_busy(busy[1]));

    signal_gen #(.DATA_W(8), .CNT_W(10), .MODE(1), .SMP_DIV(4), .RUN_LEN(RUN_LEN),
                 .SYM_LEN(SYM_LEN), .ONE_HI(ONE_HI), .ZERO_HI(ZERO_HI)) dut_div (
        .i_clk(clk), .i_rst(rst), .i_tx_vld(tx_vld[2]), .i_tx_data(tx_data[2]),
        .o_tx_rdy(rdy[2]), .o_vld(vld[2]), .o_vld_data(vdat[2]), .o_busy(busy[2]));

    task automatic model_push(input bit pwm, input logic [7:0] w, output int n);
        logic [8:0] fr;
        logic       b;
        int         hi;
        fr = {w, ^w};
        n  = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            b = fr[8-i];
            if (!pwm) begin
                for (int j = 0; j < RUN_LEN; j++) begin
                    sb_q.push_back(b);
                    n++;
                end
            end else begin
                hi = b ? ONE_HI : ZERO_HI;
                for (int j = 0; j < SYM_LEN; j++) begin
                    sb_q.push_back(j < hi);
                    n++;
                end
            end
        end
    endtask

    task automatic wait_rdy(input int d, input string name);
        for (int i = 0; i < 400 && !rdy[d]; i++) @(negedge clk);
        n_vec++;
        if (!rdy[d]) begin
            n_err++;
            $display("FAIL %s rdy_timeout: rdy=%b required 1", name, rdy[d]);
        end
    endtask

    task automatic send_and_check(input int d, input logic [7:0] w, input int div,
                                  input string name);
        int   n_smp, first_k, last_k, rdy_k, got, bad_period, busy_k1;
        logic exp_v, prev_vdat;
        model_push(d == 1, w, n_smp);
        wait_rdy(d, name);
        @(negedge clk);
        tx_vld[d]  = 1'b1;
        tx_data[d] = w;
        @(posedge clk);
        #1;
        tx_vld[d]  = 1'b0;
        tx_data[d] = ~w;
        first_k = -1; last_k = -1; rdy_k = -1; got = 0; bad_period = 0; busy_k1 = 0;
        prev_vdat = vdat[d];
        for (int k = 1; k <= n_smp * div + 10 && rdy_k < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) busy_k1 = int'(busy[d]);
            if (vld[d]) begin
                if (first_k < 0) first_k = k;
                else if (k - last_k != div) bad_period++;
                last_k = k;
                got++;
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_sample at clk %0d", name, k);
                end else begin
                    exp_v = sb_q.pop_front();
                    if (vdat[d] !== exp_v) begin
                        n_err++;
                        $display("FAIL %s sample %0d: got %b required %b", name, got, vdat[d], exp_v);
                    end
                end
            end else if (vdat[d] !== prev_vdat) begin
                n_err++;
                $display("FAIL %s data_glitch at clk %0d: got %b required %b", name, k, vdat[d], prev_vdat);
            end
            prev_vdat = vdat[d];
            if (rdy[d]) rdy_k = k;
        end
        n_vec += 6;
        if (first_k !== 1) begin
            n_err++; $display("FAIL %s first_vld_clk: got %0d required 1", name, first_k);
        end
        if (bad_period !== 0) begin
            n_err++; $display("FAIL %s vld_period: %0d gaps differ from required %0d", name, bad_period, div);
        end
        if (got !== n_smp) begin
            n_err++; $display("FAIL %s sample_count: got %0d required %0d", name, got, n_smp);
        end
        if (rdy_k !== n_smp * div + 1) begin
            n_err++; $display("FAIL %s rdy_return_clk: got %0d required %0d", name, rdy_k, n_smp * div + 1);
        end
        if (busy_k1 !== 1 || busy[d] !== 1'b0) begin
            n_err++; $display("FAIL %s busy: first=%0d end=%b required 1/0", name, busy_k1, busy[d]);
        end
        if (sb_q.size() !== 0) begin
            n_err++; $display("FAIL %s missing_samples: %0d left required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if ({rdy[d], vld[d], vdat[d], busy[d]} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_state dut%0d: rdy/vld/data/busy=%b%b%b%b required 0000",
                         d, rdy[d], vld[d], vdat[d], busy[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (rdy !== 3'b111 || busy !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b busy=%b required 111/000", rdy, busy);
        end
    endtask

    task automatic test_owt();
        send_and_check(0, 8'hA5, 1, "owt_a5");
        send_and_check(0, 8'h3E, 1, "owt_3e");
    endtask

    task automatic test_pwm();
        send_and_check(1, 8'h80, 1, "pwm_80");
        send_and_check(1, 8'h5A, 1, "pwm_5a");
    endtask

    task automatic test_div();
        send_and_check(2, 8'hFF, 4, "div4_ff");
        send_and_check(2, 8'h00, 4, "div4_00");
    endtask

    task automatic test_back_to_back();
        int   n1, n2, rdy_first, got;
        logic exp_v;
        model_push(0, 8'h01, n1);
        model_push(0, 8'h02, n2);
        wait_rdy(0, "b2b");
        @(negedge clk);
        tx_vld[0]  = 1'b1;
        tx_data[0] = 8'h01;
        @(posedge clk);
        #1;
        tx_data[0] = 8'h02;
        rdy_first = -1;
        got = 0;
        for (int k = 1; k <= n1 + n2 + 3; k++) begin
            @(posedge clk);
            #1;
            if (vld[0]) begin
                got++;
                n_vec++;
                exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 1'bx;
                if (vdat[0] !== exp_v) begin
                    n_err++;
                    $display("FAIL b2b sample %0d: got %b required %b", got, vdat[0], exp_v);
                end
            end
            if (rdy_first > 0 && k == rdy_first + 1) begin
                n_vec++;
                if (rdy[0] !== 1'b0 || busy[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b second_accept: rdy=%b busy=%b required 0/1", rdy[0], busy[0]);
                end
                tx_vld[0]  = 1'b0;
                tx_data[0] = 8'hEE;
            end
            if (rdy[0] && rdy_first < 0) rdy_first = k;
        end
        tx_vld[0] = 1'b0;
        n_vec += 3;
        if (rdy_first !== n1 + 1) begin
            n_err++; $display("FAIL b2b idle_gap: rdy rose at clk %0d required %0d", rdy_first, n1 + 1);
        end
        if (got !== n1 + n2 || sb_q.size() !== 0) begin
            n_err++; $display("FAIL b2b sample_count: got %0d required %0d", got, n1 + n2);
            sb_q.delete();
        end
        if (rdy[0] !== 1'b1) begin
            n_err++; $display("FAIL b2b end_rdy: got %b required 1", rdy[0]);
        end
    endtask

    task automatic test_mid_reset();
        int cnt;
        wait_rdy(0, "mid_rst");
        @(negedge clk);
        tx_vld[0]  = 1'b1;
        tx_data[0] = 8'hA5;
        @(posedge clk);
        #1;
        tx_vld[0] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 20; k++) begin
            @(posedge clk);
            #1;
            if (vld[0]) cnt++;
        end
        n_vec++;
        if (cnt !== 20) begin
            n_err++; $display("FAIL mid_rst reach_sample20: got %0d required 20", cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({vld[0], busy[0], vdat[0], rdy[0]} !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_rst abort: vld/busy/data/rdy=%b%b%b%b required 0000",
                     vld[0], busy[0], vdat[0], rdy[0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        send_and_check(0, 8'h3C, 1, "post_rst_3c");
    endtask

`ifdef SIGNAL_GEN_PARITY_EN
    task automatic test_parity();
        send_and_check(0, 8'h07, 1, "par_07");
        send_and_check(0, 8'h03, 1, "par_03");
        send_and_check(1, 8'h01, 1, "par_pwm_01");
    endtask
`endif

    initial begin
        for (int d = 0; d < 3; d++) tx_data[d] = 8'h00;
        test_reset();
        test_owt();
        test_pwm();
        test_div();
        test_back_to_back();
        test_mid_reset();
`ifdef SIGNAL_GEN_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
